ysyx_24100005_ifu: RTL and testbench

Multi-cycle instruction fetch unit for the NPC core. It accepts a fetch PC from the PC/write-back logic, issues a single read to instruction memory over a valid/ready address and data channel, and presents the fetched word with its PC to the decode/execute datapath under a valid/ready handshake. It replaces direct `inst` injection from the simulator, so the core runs on a real fetch bus.

---
 rtl/ysyx_24100005_pkg.sv | 14 +
 rtl/ysyx_24100005_ifu_if.sv | 31 +++
 rtl/ysyx_24100005_ifu_wdt.sv | 37 +++
 rtl/ysyx_24100005_ifu.sv | 130 +++++++++++++
 tb/tb_ysyx_24100005_ifu.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100005_pkg.sv
// Shared NPC definitions: IFU state encodings, bus response codes and the reset PC.
package ysyx_24100005_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-side bundle: PC request, instruction-memory read channels and instruction output.
interface ysyx_24100005_ifu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              mem_arvalid;
    logic [ADDR_W-1:0] mem_araddr;
    logic              mem_arready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_rresp;
    logic              mem_rready;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_err;

    modport master (
        input  pc_in, pc_valid, mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready,
        output pc_ready, mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc, inst_err
    );

    modport slave (
        output pc_in, pc_valid, mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready,
        input  pc_ready, mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc, inst_err
    );
endinterface

// File: rtl/ysyx_24100005_ifu_wdt.sv
// Fetch watchdog: counts ADDR+DATA cycles and flags expiry on the last allowed cycle.
// Only present when YSYX_24100005_IFU_TIMEOUT_EN is defined.
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
module ysyx_24100005_ifu_wdt #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);
endmodule
`endif

// File: rtl/ysyx_24100005_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding read per PC, result held until consumed.
// Optional fetch timeout enabled by defining YSYX_24100005_IFU_TIMEOUT_EN.
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_24100005_ifu_if.master bus
);
    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;
    logic              stale_q;
    logic              timeout;
    logic              pc_fire;

`ifdef YSYX_24100005_IFU_TIMEOUT_EN
    logic stale_d;

    ysyx_24100005_ifu_wdt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == IFU_IDLE),
        .en      ((state_q == IFU_ADDR) || (state_q == IFU_DATA)),
        .expired (timeout)
    );

    // A response is still owed if the address was accepted but data never came back.
    always_comb begin
        stale_d = stale_q;
        if (stale_q && bus.mem_rvalid) begin
            stale_d = 1'b0;
        end
        if (timeout && (((state_q == IFU_ADDR) && bus.mem_arready) ||
                        ((state_q == IFU_DATA) && !bus.mem_rvalid))) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stale_q <= 1'b0;
        end else begin
            stale_q <= stale_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign stale_q = 1'b0;
    assign timeout = 1'b0;
`endif

    assign bus.pc_ready    = (state_q == IFU_IDLE) && !rst && !stale_q;
    assign pc_fire         = bus.pc_valid && bus.pc_ready;
    assign bus.mem_arvalid = (state_q == IFU_ADDR);
    assign bus.mem_araddr  = pc_q;
    assign bus.mem_rready  = (state_q == IFU_DATA) || stale_q;
    assign bus.inst_valid  = (state_q == IFU_HOLD);
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = pc_q;
    assign bus.inst_err    = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            IFU_IDLE: begin
                if (pc_fire) begin
                    pc_d   = bus.pc_in;
                    inst_d = '0;
                    if (bus.pc_in[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = IFU_HOLD;
                    end else begin
                        err_d   = 1'b0;
                        state_d = IFU_ADDR;
                    end
                end
            end
            IFU_ADDR: begin
                if (timeout) begin
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = IFU_HOLD;
                end else if (bus.mem_arready) begin
                    state_d = IFU_DATA;
                end
            end
            IFU_DATA: begin
                if (bus.mem_rvalid) begin
                    err_d   = (bus.mem_rresp != RESP_OKAY);
                    inst_d  = (bus.mem_rresp == RESP_OKAY) ? bus.mem_rdata : '0;
                    state_d = IFU_HOLD;
                end else if (timeout) begin
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (bus.inst_ready) begin
                    state_d = IFU_IDLE;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFU_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit: latency, wait states, errors, hold, reset and timeout.
module tb_ysyx_24100005_ifu;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_24100005_ifu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_24100005_ifu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one PC from IDLE and plays memory with the given wait states; returns in the first HOLD cycle.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata, input logic [1:0] resp,
                            input int ar_wait, input int r_wait,
                            output int lat, output logic saw_ar, output logic addr_ok);
        int ar_cnt = 0;
        int r_cnt  = 0;
        bit done   = 0;
        lat     = -1;
        saw_ar  = 1'b0;
        addr_ok = 1'b1;
        bus.pc_in    = pc;
        bus.pc_valid = 1'b1;
        tick();
        bus.pc_valid = 1'b0;
        for (int cyc = 1; cyc < 200 && !done; cyc++) begin
            bus.mem_arready = 1'b0;
            bus.mem_rvalid  = 1'b0;
            if (bus.inst_valid) begin
                lat  = cyc;
                done = 1;
            end else begin
                if (bus.mem_arvalid) begin
                    saw_ar = 1'b1;
                    if (bus.mem_araddr !== pc) addr_ok = 1'b0;
                    ar_cnt++;
                    bus.mem_arready = (ar_cnt > ar_wait);
                end
                if (bus.mem_rready) begin
                    r_cnt++;
                    bus.mem_rvalid = (r_cnt > r_wait);
                    bus.mem_rdata  = rdata;
                    bus.mem_rresp  = resp;
                end
                tick();
            end
        end
        if (!done) check("fetch_done", 32'd0, 32'd1);
    endtask

    int   lat;
    logic saw_ar, addr_ok;

    initial begin
        rst             = 1'b1;
        bus.pc_in       = '0;
        bus.pc_valid    = 1'b0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rresp   = 2'b00;
        bus.inst_ready  = 1'b0;
        tick();
        tick();
        check("rst_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
        check("rst_arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
        check("rst_rready", {31'd0, bus.mem_rready}, 32'd0);
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_err", {31'd0, bus.inst_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_pc_ready", {31'd0, bus.pc_ready}, 32'd1);

        // Zero-wait fetch
        bus.inst_ready = 1'b1;
        do_fetch(32'h8000_0000, 32'h0010_0093, 2'b00, 0, 0, lat, saw_ar, addr_ok);
        check("zw_latency", lat, 32'd3);
        check("zw_inst", bus.inst, 32'h0010_0093);
        check("zw_inst_pc", bus.inst_pc, 32'h8000_0000);
        check("zw_err", {31'd0, bus.inst_err}, 32'd0);
        check("zw_addr", {31'd0, addr_ok}, 32'd1);
        tick();
        check("zw_pc_ready_c4", {31'd0, bus.pc_ready}, 32'd1);
        check("zw_valid_c4", {31'd0, bus.inst_valid}, 32'd0);

        // Wait states on both channels
        do_fetch(32'h8000_0004, 32'h0020_0113, 2'b00, 3, 2, lat, saw_ar, addr_ok);
        check("ws_latency", lat, 32'd8);
        check("ws_addr_stable", {31'd0, addr_ok}, 32'd1);
        check("ws_inst", bus.inst, 32'h0020_0113);
        check("ws_inst_pc", bus.inst_pc, 32'h8000_0004);
        tick();

        // Misaligned PC: no bus access
        do_fetch(32'h8000_0002, 32'h1111_1111, 2'b00, 0, 0, lat, saw_ar, addr_ok);
        check("mis_latency", lat, 32'd1);
        check("mis_no_ar", {31'd0, saw_ar}, 32'd0);
        check("mis_err", {31'd0, bus.inst_err}, 32'd1);
        check("mis_inst", bus.inst, 32'd0);
        check("mis_inst_pc", bus.inst_pc, 32'h8000_0002);
        tick();

        // Bus error response
        do_fetch(32'h8000_0008, 32'hdead_beef, 2'b10, 0, 0, lat, saw_ar, addr_ok);
        check("berr_latency", lat, 32'd3);
        check("berr_inst", bus.inst, 32'd0);
        check("berr_err", {31'd0, bus.inst_err}, 32'd1);
        tick();

        // Back-pressure in HOLD, with stray rvalid that must be ignored
        bus.inst_ready = 1'b0;
        do_fetch(32'h8000_000c, 32'h0000_0513, 2'b00, 0, 0, lat, saw_ar, addr_ok);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hffff_ffff;
            tick();
            check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("hold_inst", bus.inst, 32'h0000_0513);
            check("hold_pc", bus.inst_pc, 32'h8000_000c);
            check("hold_err", {31'd0, bus.inst_err}, 32'd0);
            check("hold_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
            check("hold_rready", {31'd0, bus.mem_rready}, 32'd0);
        end
        bus.mem_rvalid = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        check("hold_release_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("hold_release_ready", {31'd0, bus.pc_ready}, 32'd1);

        // Reset pulsed while in DATA
        bus.pc_in    = 32'h8000_0010;
        bus.pc_valid = 1'b1;
        tick();
        bus.pc_valid = 1'b0;
        check("mr_arvalid", {31'd0, bus.mem_arvalid}, 32'd1);
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        check("mr_rready", {31'd0, bus.mem_rready}, 32'd1);
        rst = 1'b1;
        tick();
        check("mr_state_out", {28'd0, bus.mem_arvalid, bus.mem_rready, bus.inst_valid, bus.pc_ready}, 32'd0);
        check("mr_inst", bus.inst, 32'd0);
        check("mr_inst_pc", bus.inst_pc, 32'd0);
        check("mr_err", {31'd0, bus.inst_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("mr_pc_ready", {31'd0, bus.pc_ready}, 32'd1);

`ifdef YSYX_24100005_IFU_TIMEOUT_EN
        // Data never returns: 1 ADDR + 7 DATA cycles, then HOLD with error
        do_fetch(32'h8000_0020, 32'h0, 2'b00, 0, 100000, lat, saw_ar, addr_ok);
        check("to_latency", lat, 32'd9);
        check("to_err", {31'd0, bus.inst_err}, 32'd1);
        check("to_inst", bus.inst, 32'd0);
        tick();
        check("to_stale_rready", {31'd0, bus.mem_rready}, 32'd1);
        bus.pc_in    = 32'h8000_0024;
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("to_pc_blocked", {31'd0, bus.pc_ready}, 32'd0);
            tick();
            check("to_no_ar", {31'd0, bus.mem_arvalid}, 32'd0);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.pc_valid   = 1'b0;
        check("to_absorbed_ready", {31'd0, bus.pc_ready}, 32'd1);
        check("to_absorbed_rready", {31'd0, bus.mem_rready}, 32'd0);
        check("to_absorbed_inst", bus.inst, 32'd0);
        do_fetch(32'h8000_0024, 32'h0000_0013, 2'b00, 0, 0, lat, saw_ar, addr_ok);
        check("to_next_latency", lat, 32'd3);
        check("to_next_inst", bus.inst, 32'h0000_0013);
        check("to_next_err", {31'd0, bus.inst_err}, 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
